mips_cpu_muldiv: RTL and testbench
==================================

// Module: mips_cpu_muldiv
// PURPOSE
//  Iterative multiply/divide unit with the HI/LO register pair for the Harvard MIPS core.
//  Sits beside the ALU and consumes the same register-file operands (rs -> a, rt -> b).
//  Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO; hi/lo feed the MFHI/MFLO result path.
//  busy is the stall request to control: the PC and pipeline are held while it is high.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  clk_enable  in   1      global enable; 0 freezes all state, start ignored
//  start       in   1      op request, sampled on an edge with clk_enable=1
//  op          in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//  a           in   WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
//  b           in   WIDTH  rt operand (multiplier/divisor)
//  busy        out  1      iterative op in progress; hi/lo hold previous values
//  done        out  1      one-cycle pulse: hi/lo were updated on the preceding edge
//  hi          out  WIDTH  HI register (MFHI source)
//  lo          out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//  Reset (async, any state, including mid-operation):
//   hi=0, lo=0, busy=0, done=0, state=IDLE, count=0; any in-flight op is discarded.
//  FSM: IDLE -> MUL | DIV -> FIX -> IDLE.
//   Nothing advances on an edge with clk_enable=0.
//  IDLE:
//   start & MULT/MULTU -> MUL; start & DIV/DIVU -> DIV.
//   Capture |a|, |b| (signed ops) or a, b (unsigned) and the result sign flags; count=0.
//   start & MTHI/MTLO -> hi<=a or lo<=a on the same edge; no busy, no done.
//   Op codes 11x are ignored.
//  MUL: radix-2 shift-add, one bit per cycle, 32 cycles, into a 64-bit accumulator.
//  DIV: restoring division, one quotient bit per cycle, 32 cycles.
//  FIX: one cycle, then IDLE.
//   Apply two's-complement sign correction and write hi/lo.
//   done=1 the following cycle.
//  Latency: busy=1 for exactly 33 enabled cycles after the accept edge.
//   The edge ending FIX writes hi/lo, clears busy and sets done for 1 cycle.
//  Arithmetic:
//   MULT/MULTU: {hi,lo} = a*b (signed/unsigned 64-bit).
//   DIV: quotient truncates toward zero; remainder takes the sign of the dividend. lo=quot, hi=rem.
//  Boundaries:
//   b=0 (DIV/DIVU): lo=FFFFFFFF, hi=a (raw operand), same 33-cycle latency.
//   DIV 80000000 / FFFFFFFF: lo=80000000, hi=0 (wraps, no trap).
//   start while busy (any op, including MTHI/MTLO): ignored; control must stall.
//   Inputs a/b/op are don't-care after the accept edge (operands are captured).
//   clk_enable low mid-operation: count and state freeze; busy stays 1.
// STRUCTURE
//  mips_cpu_pkg holds:
//   muldiv_op_t enum (the op encodings above).
//   muldiv_state_t enum {IDLE, MUL, DIV, FIX}.
//   MULDIV_ITER = 32.
//  Sub-module mips_cpu_div_core: the restoring-divide iteration registers (rem/quot/count).
//  The multiply accumulator, sign handling and the HI/LO registers stay in this module.
// TESTING
//  1. MULT a=FFFFFFFD (-3), b=7 -> busy 33 cycles, then hi=FFFFFFFF, lo=FFFFFFEB, done 1 cycle.
//  2. MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//     MULT with the same operands -> hi=0, lo=1.
//  3. DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIVU a=100, b=7 -> lo=0000000E, hi=00000002.
//  4. DIV a=5, b=0 -> lo=FFFFFFFF, hi=00000005.
//     DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  5. Issue DIV; at busy cycle 5 pulse start with MTHI a=1234 -> ignored.
//     Drop clk_enable for 5 cycles -> busy lasts 38 cycles; hi is the remainder, not 1234.
//     MTLO a=CAFE while idle -> lo=0000CAFE next cycle, busy stays 0.
//  6. Assert reset at busy cycle 10 of a DIV -> hi=lo=0 and busy=0 with no clock edge.
//     After release, MULTU 6*7 -> lo=2A, hi=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
//   muldiv_op_t    : op-code encodings presented on the op port
//   muldiv_state_t : sequencer states of the iterative unit
//   MULDIV_ITER    : iterations per multiply/divide (one bit per cycle)
package mips_cpu_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP0  = 3'b110,
        OP_NOP1  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

    // MULT and DIV are the signed ops; their unsigned twins have bit 0 set.
    function automatic logic op_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mips_cpu_div_core.sv
// Restoring-divide datapath for the multiply/divide unit, plus the shared
// iteration counter that also paces the multiplier.
//   clk, reset       : clock, asynchronous active-low reset
//   clk_enable       : global enable; 0 freezes every register
//   load             : capture dividend/divisor and clear rem/count
//   iter             : perform one iteration (one quotient bit)
//   dividend,divisor : unsigned magnitudes
//   quot, rem        : unsigned quotient and remainder after WIDTH iterations
//   last             : the current iteration is the final one
module mips_cpu_div_core
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             load,
    input  logic             iter,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [CW-1:0]  count;
    logic [WIDTH-1:0] dsor;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // Partial remainder shifted left with the next dividend bit, which sits
    // at the top of the quotient register until it is shifted out.
    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        rem_sh = {rem, quot[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsor};
    end

    assign last = (count == LAST_COUNT);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            rem   <= '0;
            quot  <= '0;
            dsor  <= '0;
        end else if (clk_enable) begin
            if (load) begin
                count <= '0;
                rem   <= '0;
                quot  <= dividend;
                dsor  <= divisor;
            end else if (iter) begin
                count <= count + 1'b1;
                // A clear borrow means the divisor fit: keep the difference.
                // A zero divisor always fits, giving an all-ones quotient and
                // the dividend as remainder.
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                end else begin
                    rem <= rem_sh[WIDTH-1:0];
                end
                quot <= {quot[WIDTH-2:0], ~trial[WIDTH]};
            end
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit with the HI/LO register pair.
//   clk, reset     : clock, asynchronous active-low reset
//   clk_enable     : global enable; 0 freezes all state and ignores start
//   start, op      : op request (MULT/MULTU/DIV/DIVU/MTHI/MTLO, 11x no-op)
//   a, b           : rs / rt operands
//   busy           : iterative op in flight; pipeline must stall
//   done           : one-cycle pulse after hi/lo were written by an op
//   hi, lo         : HI/LO registers
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t    state;
    muldiv_op_t       op_e;
    logic [2*WIDTH-1:0] acc;     // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0] mcand;
    logic             neg_lo;    // negate product / quotient in FIX
    logic             neg_hi;    // negate remainder in FIX
    logic             is_mul;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             mul_req, div_req, accept;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quot, rem, quot_fix, rem_fix;
    logic             last;

    assign op_e = muldiv_op_t'(op);

    always_comb begin
        sa      = op_is_signed(op) & a[WIDTH-1];
        sb      = op_is_signed(op) & b[WIDTH-1];
        mag_a   = sa ? -a : a;
        mag_b   = sb ? -b : b;
        mul_req = (op_e == OP_MULT) || (op_e == OP_MULTU);
        div_req = (op_e == OP_DIV)  || (op_e == OP_DIVU);
        accept  = clk_enable && start && (state == IDLE) && (mul_req || div_req);
        // Shift-add: add the multiplicand into the upper half when the
        // multiplier LSB is set, carry kept so the right shift is exact.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        product  = neg_lo ? -acc : acc;
        quot_fix = neg_lo ? -quot : quot;
        rem_fix  = neg_hi ? -rem : rem;
    end

    mips_cpu_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .load       (accept),
        .iter       ((state == MUL) || (state == DIV)),
        .dividend   (mag_a),
        .divisor    (mag_b),
        .quot       (quot),
        .rem        (rem),
        .last       (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            mcand  <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            is_mul <= 1'b0;
        end else if (clk_enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_e)
                            OP_MULT, OP_MULTU: begin
                                state  <= MUL;
                                busy   <= 1'b1;
                                is_mul <= 1'b1;
                                acc    <= {{WIDTH{1'b0}}, mag_b};
                                mcand  <= mag_a;
                                neg_lo <= sa ^ sb;
                                neg_hi <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state  <= DIV;
                                busy   <= 1'b1;
                                is_mul <= 1'b0;
                                // Divide by zero keeps the raw all-ones quotient;
                                // the remainder still takes the dividend sign,
                                // which reproduces the raw a operand.
                                neg_lo <= (sa ^ sb) && (b != '0);
                                neg_hi <= sa;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    if (last) state <= FIX;
                end
                DIV: begin
                    if (last) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_mul) begin
                        {hi, lo} <= product;
                    end else begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// cycle-count/arithmetic reference model.
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    int busy_run = 0;
    int last_busy_len = 0;

    always #5 clk = ~clk;

    mips_cpu_muldiv dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an op: {hi, lo}.
    function automatic logic [63:0] calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic signed [31:0] sx, sy, q, r;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Reference model: an accepted mul/div owns the unit for 33 enabled
    // cycles, then the result lands in hi/lo with a one-cycle done.
    int          m_cnt = 0;
    logic [63:0] m_pend = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else if (clk_enable) begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    m_pend <= calc(op, a, b);
                    m_cnt  <= 33;
                end else if (op == 3'd4) begin
                    m_hi <= a;
                end else if (op == 3'd5) begin
                    m_lo <= a;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus busy run-length tracking.
    initial forever begin
        @(negedge clk);
        if (busy === 1'b1) begin
            busy_run = busy_run + 1;
        end else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
        if (cmp_en) begin
            check("cmp_busy", 64'(busy), 64'(m_cnt != 0));
            check("cmp_done", 64'(done), 64'(m_done));
            check("cmp_hi", 64'(hi), 64'(m_hi));
            check("cmp_lo", 64'(lo), 64'(m_lo));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (n >= 500) check("wait_idle_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        clk_enable = 1'b1;
        cmp_en = 1'b1;

        // 1. MULT -3 * 7
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        wait_idle();
        check("t1_busy_len", 64'(last_busy_len), 64'd33);
        check("t1_done", 64'(done), 64'd1);
        check("t1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        @(negedge clk);
        #1;
        check("t1_done_pulse", 64'(done), 64'd0);

        // 2. MULTU / MULT of all-ones
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        check("t2_multu", {hi, lo}, 64'hFFFFFFFE_00000001);
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        check("t2_mult", {hi, lo}, 64'h00000000_00000001);

        // 3. DIV -7/2, DIVU 100/7
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        check("t3_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        issue(3'd3, 32'd100, 32'd7);
        wait_idle();
        check("t3_divu", {hi, lo}, 64'h00000002_0000000E);

        // 4. divide by zero and the overflow case
        issue(3'd2, 32'd5, 32'd0);
        wait_idle();
        check("t4_div0", {hi, lo}, 64'h00000005_FFFFFFFF);
        check("t4_div0_len", 64'(last_busy_len), 64'd33);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        check("t4_ovf", {hi, lo}, 64'h00000000_80000000);

        // 5. start while busy, clk_enable stall, MTLO while idle
        issue(3'd2, 32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = 3'd4;
        a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        clk_enable = 1'b1;
        wait_idle();
        check("t5_busy_len", 64'(last_busy_len), 64'd38);
        check("t5_div", {hi, lo}, 64'h00000006_0000008E);
        issue(3'd5, 32'h0000CAFE, 32'd0);
        #1;
        check("t5_mtlo", 64'(lo), 64'h0000CAFE);
        check("t5_mtlo_busy", 64'(busy), 64'd0);

        // 6. asynchronous reset mid-divide
        issue(3'd2, 32'd12345, 32'd67);
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(3'd1, 32'd6, 32'd7);
        wait_idle();
        check("t6_multu", {hi, lo}, 64'h00000000_0000002A);

        // Randomized traffic: ops, operand corners, enable drops, starts while busy.
        repeat (3000) begin
            @(negedge clk);
            clk_enable = ($urandom % 8) != 0;
            start = ($urandom % 4) == 0;
            op = 3'($urandom);
            a = pick();
            b = pick();
        end
        @(negedge clk);
        start = 1'b0;
        clk_enable = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
